rx_word_ctrl: RTL and testbench

RX_WORD_CTRL -- requirements
Module: rx_word_ctrl

---
 rtl/rsa_uart_pkg.sv | 13 +
 rtl/rx_word_ctrl.sv | 95 +++++++++
 tb/tb_rx_word_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_uart_pkg.sv
// Shared definitions for the RSA UART front end: EOT character and the
// rx_word_ctrl state encoding.
package rsa_uart_pkg;

    localparam logic [7:0] EOT_CHAR = 8'h04;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_ACK  = 2'd1,
        ST_EMIT = 2'd2
    } rx_word_state_t;

endpackage

// File: rtl/rx_word_ctrl.sv
// Packs received UART bytes into BYTES-wide words, little-endian by arrival
// order, and hands them downstream with a valid/ready handshake.
module rx_word_ctrl
    import rsa_uart_pkg::*;
#(
    parameter int unsigned BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_flag,
    input  logic                         rx_eot,
    input  logic [7:0]                   rx_data,
    output logic                         rx_clear,
    output logic [8*BYTES-1:0]           word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         word_last,
    output logic [$clog2(BYTES+1)-1:0]   word_nbytes,
    output logic                         busy
);

    localparam int unsigned CW = $clog2(BYTES + 1);

    rx_word_state_t     r_state;
    rx_word_state_t     w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_eot;
    logic [8*BYTES-1:0] r_word;
    logic               w_accept;
    logic               w_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (rx_flag) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if ((r_cnt == CW'(BYTES)) || r_eot) begin
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_EMIT: begin
                if (word_ready) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    // The EOT byte itself is never stored; it only marks the word as last.
    always_ff @(posedge clk) begin
        if (rst || w_xfer) begin
            r_cnt  <= '0;
            r_eot  <= 1'b0;
            r_word <= '0;
        end else if (w_accept) begin
            if (rx_eot) begin
                r_eot <= 1'b1;
            end else begin
                for (int unsigned k = 0; k < BYTES; k++) begin
                    if (r_cnt == CW'(k)) begin
                        r_word[8*k +: 8] <= rx_data;
                    end
                end
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign rx_clear    = (r_state == ST_ACK);
    assign word_valid  = (r_state == ST_EMIT);
    assign word_out    = r_word;
    assign word_last   = r_eot;
    assign word_nbytes = r_cnt;
    assign busy        = (r_state != ST_WAIT) || (r_cnt != '0);

endmodule

// File: tb/tb_rx_word_ctrl.sv
// Scoreboard bench for rx_word_ctrl (BYTES=4) with a simple RX flag model.
module tb_rx_word_ctrl;
    import rsa_uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_flag = 1'b0;
    logic        rx_eot = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_clear;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        word_last;
    logic [2:0]  word_nbytes;
    logic        busy;

    typedef struct packed {
        logic [31:0] w;
        logic [2:0]  n;
        logic        l;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   clear_cnt = 0;
    int   xfer_cnt = 0;
    logic prev_clear = 1'b0;

    rx_word_ctrl #(.BYTES(4)) dut (
        .clk(clk), .rst(rst), .rx_flag(rx_flag), .rx_eot(rx_eot),
        .rx_data(rx_data), .rx_clear(rx_clear), .word_out(word_out),
        .word_valid(word_valid), .word_ready(word_ready),
        .word_last(word_last), .word_nbytes(word_nbytes), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [2:0] n, input logic l);
        exp_t x;
        x.w = w; x.n = n; x.l = l;
        q.push_back(x);
    endtask

    // Monitor: samples on the falling edge, between input updates and the next transfer edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_clear) begin
                check("rx_clear_single_cycle", 32'(prev_clear), 32'd0);
                clear_cnt++;
            end
            if (word_valid && word_ready) begin
                xfer_cnt++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_xfer: got word %h nbytes %0d last %0d expected none",
                             word_out, word_nbytes, word_last);
                end else begin
                    e = q.pop_front();
                    check("word_out", word_out, e.w);
                    check("word_nbytes", 32'(word_nbytes), 32'(e.n));
                    check("word_last", 32'(word_last), 32'(e.l));
                end
            end
        end
        prev_clear = rx_clear;
    end

    // RX model: flag stays up through the rx_clear cycle and drops on the following edge.
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        rx_data = d;
        rx_eot  = (d == EOT_CHAR);
        rx_flag = 1'b1;
        while (rx_clear !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL rx_clear_timeout: got no rx_clear expected pulse for byte %h", d);
        end
        @(posedge clk); #1;
        rx_flag = 1'b0;
        rx_eot  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_word_out", word_out, 32'h0);
        check("rst_ctrl_bits", {26'd0, word_valid, word_last, rx_clear, busy, 2'b00}, 32'h0);
        check("rst_word_nbytes", 32'(word_nbytes), 32'd0);
    endtask

    int c0;
    int x0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_word_out", word_out, 32'h0);
        check("reset_ctrl_bits", {27'd0, word_valid, word_last, rx_clear, busy, 1'b0}, 32'h0);

        // Full word, with the completing byte timed by hand for latency.
        word_ready = 1'b1;
        c0 = clear_cnt;
        push(32'h44332211, 3'd4, 1'b0);
        send(8'h11); send(8'h22); send(8'h33);
        rx_data = 8'h44; rx_flag = 1'b1;
        @(posedge clk); #1;
        check("lat_ack_clear", 32'(rx_clear), 32'd1);
        check("lat_ack_novalid", 32'(word_valid), 32'd0);
        @(posedge clk); #1;
        rx_flag = 1'b0;
        check("lat_valid_2cyc", 32'(word_valid), 32'd1);
        drain();
        check("full_clear_pulses", 32'(clear_cnt - c0), 32'd4);

        // Partial word terminated by EOT.
        c0 = clear_cnt;
        push(32'h0000BBAA, 3'd2, 1'b1);
        send(8'hAA); send(8'hBB); send(EOT_CHAR);
        drain();
        check("partial_clear_pulses", 32'(clear_cnt - c0), 32'd3);

        // Full word then EOT gives an empty last word.
        x0 = xfer_cnt;
        push(32'h88776655, 3'd4, 1'b0);
        push(32'h00000000, 3'd0, 1'b1);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88); send(EOT_CHAR);
        drain();
        check("full_eot_xfers", 32'(xfer_cnt - x0), 32'd2);

        // Back-pressure in EMIT while the next byte is flagged.
        word_ready = 1'b0;
        c0 = clear_cnt;
        push(32'hA4A3A2A1, 3'd4, 1'b0);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        rx_data = 8'hB5; rx_flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_word_stable", word_out, 32'hA4A3A2A1);
            check("bp_valid_held", 32'(word_valid), 32'd1);
            check("bp_no_clear", 32'(rx_clear), 32'd0);
        end
        word_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_xfer_valid", 32'(word_valid), 32'd0);
        check("bp_after_xfer_clear", 32'(rx_clear), 32'd0);
        @(posedge clk); #1;
        check("bp_accept_next", 32'(rx_clear), 32'd1);
        @(posedge clk); #1;
        rx_flag = 1'b0;
        push(32'h000000B5, 3'd1, 1'b1);
        send(EOT_CHAR);
        drain();
        check("bp_clear_pulses", 32'(clear_cnt - c0), 32'd6);

        // Reset mid-word discards the partial bytes.
        send(8'hDE); send(8'hAD);
        check("midword_busy", 32'(busy), 32'd1);
        pulse_rst();
        push(32'h04030201, 3'd4, 1'b0);
        send(8'h01); send(8'h02); send(8'h03);
        rx_eot = 1'b0;
        // 8'h04 as a data byte: rx_eot is driven from the RX side, not from the value.
        rx_data = 8'h04; rx_flag = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rx_flag = 1'b0;
        drain();

        // Reset during EMIT discards the pending word.
        word_ready = 1'b0;
        x0 = xfer_cnt;
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        check("emit_before_rst", 32'(word_valid), 32'd1);
        pulse_rst();
        word_ready = 1'b1;
        push(32'h00000000, 3'd0, 1'b1);
        send(EOT_CHAR);
        drain();
        check("emit_rst_xfers", 32'(xfer_cnt - x0), 32'd1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
